// File: rtl/data_memory_responder_pkg.sv
// rtl/data_memory_responder_pkg.sv - shared encodings for the data-memory responder
package data_memory_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

    // One bit per reason a request is refused; any set bit marks it bad.
    localparam logic [2:0] BAD_MISALIGN = 3'b001;
    localparam logic [2:0] BAD_RANGE    = 3'b010;
    localparam logic [2:0] BAD_CONFLICT = 3'b100;

    function automatic logic [2:0] bad_reasons(
        input logic        rd,
        input logic        wr,
        input logic [31:0] addr,
        input int unsigned depth
    );
        logic [2:0] r;
        r = 3'b000;
        if (addr[1:0] != 2'b00) begin
            r = r | BAD_MISALIGN;
        end
        if ({2'b00, addr[31:2]} >= depth) begin
            r = r | BAD_RANGE;
        end
        if (rd && wr) begin
            r = r | BAD_CONFLICT;
        end
        return r;
    endfunction

endpackage

// File: rtl/data_memory_responder_array.sv
// rtl/data_memory_responder_array.sv - word-addressed storage with registered read port
module data_mem_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rd_en,
    input  logic             rd_clr,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [31:0]      wr_data,
    output logic [31:0]      rd_data
);

    logic [31:0] mem [DEPTH_WORDS];

    // Storage itself is never reset; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Read register doubles as the responder's data output, so it is reset and clearable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= 32'd0;
        end else if (rd_en) begin
            rd_data <= mem[rd_idx];
        end else if (rd_clr) begin
            rd_data <= 32'd0;
        end
    end

endmodule

// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - fixed-latency load/store responder with pipeline stall
module data_memory_responder
    import data_memory_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        stall_o,
    output logic        valid_o,
    output logic        err_o
);

    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    op_t                op_q;
    logic [IDX_W-1:0]   idx_q;
    logic [31:0]        wdata_q;
    logic               bad_q;

    logic               req;
    logic               accept;
    logic               bad_in;
    op_t                op_in;
    logic [IDX_W-1:0]   idx_in;
    logic               enter_resp;
    logic               acc_bad;
    op_t                acc_op;
    logic [IDX_W-1:0]   acc_idx;
    logic               rd_en;
    logic               rd_clr;
    logic               wr_en;

    assign req    = MemRead_i | MemWrite_i;
    assign accept = (state_q == IDLE) && req;
    assign bad_in = |bad_reasons(MemRead_i, MemWrite_i, addr_i, DEPTH_WORDS);
    assign op_in  = MemWrite_i ? OP_WR : OP_RD;
    assign idx_in = addr_i[IDX_W+1:2];

    // State, countdown and request latches; latches load only when a request is taken.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            op_q    <= OP_RD;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                op_q    <= op_in;
                idx_q   <= idx_in;
                wdata_q <= data_i;
                bad_q   <= bad_in;
            end
        end
    end

    // Next-state and countdown; flags the edge on which RESP is entered.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    cnt_d = CNT_LOAD;
                    if (LATENCY == 1) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // With LATENCY==1 RESP is entered straight from IDLE, before the latches hold the request.
    always_comb begin
        acc_bad = bad_q;
        acc_op  = op_q;
        acc_idx = idx_q;
        if (state_q == IDLE) begin
            acc_bad = bad_in;
            acc_op  = op_in;
            acc_idx = idx_in;
        end
    end

    assign rd_en  = enter_resp && !acc_bad && (acc_op == OP_RD);
    assign rd_clr = enter_resp && !rd_en;
    assign wr_en  = (state_q == RESP) && !bad_q && (op_q == OP_WR);

    assign stall_o = rst_i && (accept || (state_q == WAIT));
    assign valid_o = (state_q == RESP);
    assign err_o   = valid_o && bad_q;

    data_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk     (clk_i),
        .rst_n   (rst_i),
        .rd_en   (rd_en),
        .rd_clr  (rd_clr),
        .rd_idx  (acc_idx),
        .wr_en   (wr_en),
        .wr_idx  (idx_q),
        .wr_data (wdata_q),
        .rd_data (data_o)
    );

endmodule

// File: tb/tb_data_memory_responder.sv
// tb/tb_data_memory_responder.sv - directed vector bench for data_memory_responder
module tb_data_memory_responder;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        sel;

    logic        rd_a, wr_a, rd_b, wr_b;
    logic [31:0] addr_a, data_in_a, addr_b, data_in_b;
    logic [31:0] data_a, data_b;
    logic        stall_a, valid_a, err_a, stall_b, valid_b, err_b;

    logic [31:0] data_m;
    logic        stall_m, valid_m, err_m;

    int n_cmp;
    int n_bad;

    assign data_m  = sel ? data_b  : data_a;
    assign stall_m = sel ? stall_b : stall_a;
    assign valid_m = sel ? valid_b : valid_a;
    assign err_m   = sel ? err_b   : err_a;

    data_memory_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut_a (
        .clk_i      (clk),
        .rst_i      (rst_n),
        .MemRead_i  (rd_a),
        .MemWrite_i (wr_a),
        .addr_i     (addr_a),
        .data_i     (data_in_a),
        .data_o     (data_a),
        .stall_o    (stall_a),
        .valid_o    (valid_a),
        .err_o      (err_a)
    );

    data_memory_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut_b (
        .clk_i      (clk),
        .rst_i      (rst_n),
        .MemRead_i  (rd_b),
        .MemWrite_i (wr_b),
        .addr_i     (addr_b),
        .data_i     (data_in_b),
        .data_o     (data_b),
        .stall_o    (stall_b),
        .valid_o    (valid_b),
        .err_o      (err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] data);
        if (s) begin
            rd_b = rd; wr_b = wr; addr_b = addr; data_in_b = data;
        end else begin
            rd_a = rd; wr_a = wr; addr_a = addr; data_in_a = data;
        end
    endtask

    // Entered 1 time unit after a rising edge (cycle 0); returns at the start of cycle LATENCY+1.
    task automatic access(input logic s, input vec_t v, input string name);
        int lat;
        lat = s ? 1 : 2;
        sel = s;
        drive(s, v.rd, v.wr, v.addr, v.wdata);
        @(negedge clk);
        chk({name, " c0 stall"}, 32'(stall_m), 32'd1);
        chk({name, " c0 valid"}, 32'(valid_m), 32'd0);
        for (int i = 1; i < lat; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk({name, " wait stall"}, 32'(stall_m), 32'd1);
            chk({name, " wait valid"}, 32'(valid_m), 32'd0);
        end
        @(posedge clk);
        #1;
        drive(s, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk({name, " resp valid"}, 32'(valid_m), 32'd1);
        chk({name, " resp stall"}, 32'(stall_m), 32'd0);
        chk({name, " resp err"},   32'(err_m),   32'(v.exp_err));
        chk({name, " resp data"},  data_m,       v.exp_data);
        @(posedge clk);
        #1;
    endtask

    vec_t va[14];
    vec_t vb[6];
    vec_t v_reload;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        sel   = 1'b0;
        rst_n = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);

        //           rd    wr    addr          wdata         exp_data      err
        va[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        va[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
        va[2]  = '{1'b0, 1'b1, 32'h0000_0000, 32'hA5A5_0001, 32'h0000_0000, 1'b0};
        va[3]  = '{1'b1, 1'b0, 32'h0000_0013, 32'h0,         32'h0000_0000, 1'b1};
        va[4]  = '{1'b1, 1'b0, 32'h0000_0400, 32'h0,         32'h0000_0000, 1'b1};
        va[5]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         32'hA5A5_0001, 1'b0};
        va[6]  = '{1'b0, 1'b1, 32'h0000_0020, 32'h0000_1234, 32'h0000_0000, 1'b0};
        va[7]  = '{1'b1, 1'b1, 32'h0000_0020, 32'h0000_0055, 32'h0000_0000, 1'b1};
        va[8]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,         32'h0000_1234, 1'b0};
        va[9]  = '{1'b0, 1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
        va[10] = '{1'b1, 1'b0, 32'h0000_03FC, 32'h0,         32'hCAFE_F00D, 1'b0};
        va[11] = '{1'b0, 1'b1, 32'h0000_0400, 32'h7777_7777, 32'h0000_0000, 1'b1};
        va[12] = '{1'b0, 1'b1, 32'h0000_0008, 32'h1111_1111, 32'h0000_0000, 1'b0};
        va[13] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,         32'h1111_1111, 1'b0};

        vb[0] = '{1'b0, 1'b1, 32'h0000_0000, 32'h1000_0001, 32'h0000_0000, 1'b0};
        vb[1] = '{1'b0, 1'b1, 32'h0000_0004, 32'h2000_0002, 32'h0000_0000, 1'b0};
        vb[2] = '{1'b0, 1'b1, 32'h0000_0008, 32'h3000_0003, 32'h0000_0000, 1'b0};
        vb[3] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         32'h1000_0001, 1'b0};
        vb[4] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,         32'h2000_0002, 1'b0};
        vb[5] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,         32'h3000_0003, 1'b0};

        v_reload = '{1'b1, 1'b0, 32'h0000_0008, 32'h0, 32'h1111_1111, 1'b0};

        // Reset state, with a request already presented to dut_a.
        repeat (2) @(posedge clk);
        #1;
        chk("rst stall_a gated", 32'(stall_a), 32'd0);
        chk("rst valid_a", 32'(valid_a), 32'd0);
        chk("rst err_a",   32'(err_a),   32'd0);
        chk("rst data_a",  data_a,       32'd0);
        chk("rst stall_b", 32'(stall_b), 32'd0);
        chk("rst valid_b", 32'(valid_b), 32'd0);
        chk("rst data_b",  data_b,       32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle stall_a", 32'(stall_a), 32'd0);

        for (int i = 0; i < 14; i++) begin
            access(1'b0, va[i], $sformatf("A%0d", i));
        end

        // Reset in the WAIT cycle of a store: abort, no response, store dropped.
        sel = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0008, 32'h1234_5678);
        @(negedge clk);
        chk("abort c0 stall", 32'(stall_a), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort stall", 32'(stall_a), 32'd0);
        chk("abort valid", 32'(valid_a), 32'd0);
        chk("abort err",   32'(err_a),   32'd0);
        chk("abort data",  data_a,       32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort no valid", 32'(valid_a), 32'd0);
        end
        @(posedge clk);
        #1;
        access(1'b0, v_reload, "A reload 0x8");

        for (int i = 0; i < 6; i++) begin
            access(1'b1, vb[i], $sformatf("B%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_memory_responder.md
# data_memory_responder

Multi-cycle responder for the pipeline's data-memory port: it accepts load/store requests from the EX/MEM stage and holds the pipeline with a stall until the access completes after a fixed latency. It then returns read data toward MEM/WB with a one-cycle valid pulse. It replaces the single-cycle data memory on the memory side of that interface. Word-addressed storage is internal; misaligned, out-of-range and conflicting requests are flagged, not executed.

## Interface
- DEPTH_WORDS, 256: storage size in 32-bit words; power of two, at least 4.
- LATENCY, 2: cycles from request acceptance to response; at least 1, at most 15.

- clk_i  in  1  clock; all state changes on its rising edge.
- rst_i  in  1  reset; asynchronous, active-low.
- MemRead_i  in  1  load request, from EX/MEM.
- MemWrite_i  in  1  store request, from EX/MEM.
- addr_i  in  32  byte address, from the EX/MEM ALU result.
- data_i  in  32  store data.
- data_o  out  32  load data; registered.
- stall_o  out  1  high means the pipeline (PC, IF/ID, ID/EX, EX/MEM) must hold.
- valid_o  out  1  one-cycle pulse marking the response cycle.
- err_o  out  1  qualifies valid_o: the request was rejected.

## Operation
- FSM states: IDLE, WAIT, RESP.
- A request (req) is MemRead_i | MemWrite_i.
- IDLE, req=0: stay in IDLE.
- IDLE, req=1:
  - latch op, word index addr_i[31:2], data_i and a bad flag;
  - bad = (addr_i[1:0] != 0) | (addr_i[31:2] >= DEPTH_WORDS) | (MemRead_i & MemWrite_i);
  - load the counter with LATENCY-1;
  - go to RESP if LATENCY==1, otherwise go to WAIT.
- WAIT: decrement the counter; go to RESP when it reaches 1 before decrementing.
- Entering RESP:
  - good read: data_o <= mem[index];
  - good write or bad request: data_o <= 0.
- RESP: valid_o=1 and err_o=bad.
- Leaving RESP: a good write commits mem[index] <= latched data. Then go to IDLE unconditionally.
- stall_o = (IDLE & req) | WAIT. stall_o is 0 in RESP, so the pipeline advances on the edge that leaves RESP and MEM/WB captures data_o on that same edge.
- Requests are taken only in IDLE. Inputs during WAIT and RESP are ignored; the pipeline holds them stable anyway.
- Storage is not reset; its contents are undefined until written.

## Timing
- Reset values: FSM=IDLE, counter=0, data_o=0, valid_o=0, err_o=0, latched fields=0. stall_o is combinational and is 0 under reset.
- Reset during WAIT or RESP aborts the access with no response. A pending store is dropped and does not reach storage.
- A request visible in cycle 0 gives:
  - stall_o high in cycles 0..LATENCY-1;
  - valid_o high in cycle LATENCY;
  - a new request can be accepted in cycle LATENCY+1.
- Each access therefore adds LATENCY stall cycles.
- Back-to-back store then load to the same address: the load returns the stored value. The store commits before the load's RESP.
- Bad requests take the same latency as good ones. They never modify storage.

## Structure
- Shared package holds:
  - the state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2);
  - the op encoding (OP_RD, OP_WR);
  - the bad-request reason constants.
- The natural sub-module is data_mem_array: a word-addressed synchronous array with a registered read and a single write port. The FSM and latches stay in the top.

## Test plan
- LATENCY=2; store 0xDEADBEEF to 0x10 in cycle 0 → stall_o high in cycles 0–1, valid_o high in cycle 2 with err_o=0 and data_o=0.
- Then load from 0x10 immediately in cycle 3 → stall_o high in cycles 3–4; cycle 5 has valid_o=1 and data_o=0xDEADBEEF.
- Load from 0x13 (misaligned), and separately from 0x400 with DEPTH_WORDS=256 → valid_o=1 and err_o=1 at LATENCY, data_o=0; a following load of 0x0 shows storage unchanged.
- MemRead_i and MemWrite_i both high at address 0x20 with data 0x55 → err_o=1; a later load of 0x20 does not return 0x55.
- LATENCY=1; loads back-to-back from 0x0, 0x4, 0x8 → each stalls exactly one cycle, valid_o pulses every second cycle, data matches the preloaded words.
- Assert rst_i low in the WAIT cycle of a store of 0x12345678 to 0x8 → all outputs return to 0 immediately, no valid_o pulse, and a later load of 0x8 returns the old value.
